// File: rtl/div_param_pkg.sv
// Shared state encodings, handshake levels and sizing helpers for the
// parametrised EX-stage divider.
package div_param_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_RST_ENABLE       = 1'b0;

    // Counter must be able to hold the final iteration count itself.
    function automatic int cnt_width(input int iters);
        return $clog2(iters + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    assign shifted = {rem_in, dividend_bit};
    assign q_bit   = (shifted >= {1'b0, divisor});
    // When the subtraction succeeds the true difference is below the divisor,
    // so the low WIDTH bits are exact.
    assign rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_param.sv
// Iterative signed/unsigned restoring divider retiring STEPS quotient bits per
// cycle, with the start/stop/annul handshake of the EX-stage divider.
//
//   state  | meaning
//   FREE   | idle, outputs held at zero, waiting for start
//   BYZERO | divisor was zero, canned result already loaded
//   ON     | iterating; final pass applies the sign fix-up
//   END    | result and flags presented until start is released
module div_param
    import div_param_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_zero_o,
    output logic               overflow_o
);

    localparam int ITERS = WIDTH / STEPS;
    localparam int CNT_W = cnt_width(ITERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e state, state_next;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             neg1, neg2;
    logic             zero_flag, ovf_flag;

    logic             start_ok;
    logic             divisor_zero;
    logic             last_iter;
    logic             neg_a, neg_b;
    logic             ovf_now;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] dvd_next;
    logic [STEPS-1:0] q_bits;
    logic [WIDTH-1:0] rem_chain [STEPS+1];

    assign start_ok     = (start_i == DIV_START) && !annul_i;
    assign divisor_zero = (opdata2_i == '0);
    assign last_iter    = (cnt == CNT_LAST);
    assign neg_a        = signed_div_i & opdata1_i[WIDTH-1];
    assign neg_b        = signed_div_i & opdata2_i[WIDTH-1];
    assign mag_a        = neg_a ? -opdata1_i : opdata1_i;
    assign mag_b        = neg_b ? -opdata2_i : opdata2_i;
    assign ovf_now      = signed_div_i && (opdata1_i == MIN_VAL) && (opdata2_i == '1);
    assign busy_o       = (state != DIV_FREE);

    // Dividend bits leave from the MSB while quotient bits enter at the LSB,
    // so one register serves both and ends up holding the quotient.
    assign rem_chain[0] = rem;
    for (genvar k = 0; k < STEPS; k++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .rem_in      (rem_chain[k]),
            .divisor     (dvs),
            .dividend_bit(dvd[WIDTH-1-k]),
            .rem_out     (rem_chain[k+1]),
            .q_bit       (q_bits[STEPS-1-k])
        );
    end
    assign dvd_next = {dvd[WIDTH-1-STEPS:0], q_bits};

    always_ff @(posedge clk) begin
        if (rst == DIV_RST_ENABLE) begin
            state <= DIV_FREE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_FREE: begin
                if (start_ok) begin
                    state_next = divisor_zero ? DIV_BYZERO : DIV_ON;
                end
            end
            DIV_BYZERO: state_next = DIV_END;
            DIV_ON: begin
                if (annul_i) begin
                    state_next = DIV_FREE;
                end else if (last_iter) begin
                    state_next = DIV_END;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_next = DIV_FREE;
                end
            end
            default: state_next = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == DIV_RST_ENABLE) begin
            cnt        <= '0;
            rem        <= '0;
            dvd        <= '0;
            dvs        <= '0;
            neg1       <= 1'b0;
            neg2       <= 1'b0;
            zero_flag  <= 1'b0;
            ovf_flag   <= 1'b0;
            result_o   <= '0;
            ready_o    <= DIV_RESULT_NOT_READY;
            div_zero_o <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            case (state)
                DIV_FREE: begin
                    result_o   <= '0;
                    ready_o    <= DIV_RESULT_NOT_READY;
                    div_zero_o <= 1'b0;
                    overflow_o <= 1'b0;
                    if (start_ok) begin
                        neg1      <= neg_a;
                        neg2      <= neg_b;
                        zero_flag <= divisor_zero;
                        ovf_flag  <= ovf_now;
                        cnt       <= '0;
                        if (divisor_zero) begin
                            // Divide-by-zero result is fixed: remainder is the raw dividend.
                            rem <= opdata1_i;
                            dvd <= '1;
                            dvs <= '0;
                        end else begin
                            rem <= '0;
                            dvd <= mag_a;
                            dvs <= mag_b;
                        end
                    end
                end
                DIV_ON: begin
                    if (!annul_i) begin
                        if (!last_iter) begin
                            rem <= rem_chain[STEPS];
                            dvd <= dvd_next;
                            cnt <= cnt + CNT_W'(1);
                        end else begin
                            dvd <= (neg1 ^ neg2) ? -dvd : dvd;
                            rem <= neg1 ? -rem : rem;
                            cnt <= '0;
                        end
                    end
                end
                DIV_END: begin
                    if (start_i == DIV_STOP) begin
                        result_o   <= '0;
                        ready_o    <= DIV_RESULT_NOT_READY;
                        div_zero_o <= 1'b0;
                        overflow_o <= 1'b0;
                    end else begin
                        result_o   <= {rem, dvd};
                        ready_o    <= DIV_RESULT_READY;
                        div_zero_o <= zero_flag;
                        overflow_o <= ovf_flag;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_param.sv
// Bench for div_param: a WIDTH=32/STEPS=1 and a WIDTH=16/STEPS=4 instance
// sharing operands, checked against a queue of expected results.
module tb_div_param;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        logic        ov;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sgn;
    logic        annul;
    logic        start32, start16;
    logic [31:0] op1, op2;

    logic [63:0] res32;
    logic        rdy32, busy32, dz32, ov32;
    logic [31:0] res16;
    logic        rdy16, busy16, dz16, ov16;

    exp_t scoreboard[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    div_param #(.WIDTH(32), .STEPS(1)) u_dut32 (
        .clk(clk), .rst(rst), .signed_div_i(sgn),
        .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start32), .annul_i(annul),
        .result_o(res32), .ready_o(rdy32), .busy_o(busy32),
        .div_zero_o(dz32), .overflow_o(ov32)
    );

    div_param #(.WIDTH(16), .STEPS(4)) u_dut16 (
        .clk(clk), .rst(rst), .signed_div_i(sgn),
        .opdata1_i(op1[15:0]), .opdata2_i(op2[15:0]),
        .start_i(start16), .annul_i(annul),
        .result_o(res16), .ready_o(rdy16), .busy_o(busy16),
        .div_zero_o(dz16), .overflow_o(ov16)
    );

    function automatic logic [63:0] get_res(input bit w16);
        return w16 ? {32'd0, res16} : res32;
    endfunction
    function automatic logic get_rdy(input bit w16);
        return w16 ? rdy16 : rdy32;
    endfunction
    function automatic logic get_busy(input bit w16);
        return w16 ? busy16 : busy32;
    endfunction
    function automatic logic [1:0] get_flags(input bit w16);
        return w16 ? {dz16, ov16} : {dz32, ov32};
    endfunction

    task automatic set_start(input bit w16, input logic v);
        if (w16) start16 = v;
        else     start32 = v;
    endtask

    // Reference result from the language's truncating / and % on wide integers.
    function automatic exp_t model(input bit w16, input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        int     w;
        longint mask, sa, sb, q, r;
        w    = w16 ? 16 : 32;
        mask = (longint'(1) << w) - 1;
        sa   = longint'(a) & mask;
        sb   = longint'(b) & mask;
        if (s && sa[w-1]) sa = sa - (longint'(1) << w);
        if (s && sb[w-1]) sb = sb - (longint'(1) << w);
        e.dz = (sb == 0);
        e.ov = s && (sa == -(longint'(1) << (w-1))) && (sb == -1);
        if (e.dz) begin
            q     = mask;
            r     = longint'(a) & mask;
            e.lat = 2;
        end else begin
            q     = sa / sb;
            r     = sa % sb;
            e.lat = (w16 ? 16 / 4 : 32) + 2;
        end
        e.res = ((r & mask) << w) | (q & mask);
        return e;
    endfunction

    task automatic run_op(input bit w16, input logic s, input logic [31:0] a, input logic [31:0] b, input exp_t e);
        exp_t exp_e;
        int   lat;
        scoreboard.push_back(e);
        @(negedge clk);
        sgn = s; op1 = a; op2 = b;
        set_start(w16, 1'b1);
        @(posedge clk); #1;
        sgn = ~s; op1 = ~a; op2 = b + 32'd3;
        n_checks++;
        if (get_busy(w16) !== 1'b1 || get_rdy(w16) !== 1'b0) begin
            n_fail++;
            $display("FAIL start_state w16=%0b: busy=%b ready=%b, required busy=1 ready=0", w16, get_busy(w16), get_rdy(w16));
        end
        lat = 0;
        while (get_rdy(w16) !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        exp_e = scoreboard.pop_front();
        n_checks++;
        if (lat !== exp_e.lat) begin
            n_fail++;
            $display("FAIL latency w16=%0b a=%h b=%h: got %0d edges, required %0d", w16, a, b, lat, exp_e.lat);
        end
        n_checks++;
        if (get_res(w16) !== exp_e.res) begin
            n_fail++;
            $display("FAIL result w16=%0b s=%0b a=%h b=%h: got %h, required %h", w16, s, a, b, get_res(w16), exp_e.res);
        end
        n_checks++;
        if (get_flags(w16) !== {exp_e.dz, exp_e.ov}) begin
            n_fail++;
            $display("FAIL flags w16=%0b a=%h b=%h: got {dz,ov}=%b, required %b%b", w16, a, b, get_flags(w16), exp_e.dz, exp_e.ov);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (get_rdy(w16) !== 1'b1 || get_res(w16) !== exp_e.res) begin
            n_fail++;
            $display("FAIL hold w16=%0b: ready=%b result=%h, required ready=1 result=%h", w16, get_rdy(w16), get_res(w16), exp_e.res);
        end
        @(negedge clk);
        set_start(w16, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if (get_rdy(w16) !== 1'b0 || get_busy(w16) !== 1'b0 || get_res(w16) !== 64'd0 || get_flags(w16) !== 2'b00) begin
            n_fail++;
            $display("FAIL release w16=%0b: ready=%b busy=%b result=%h flags=%b, required all 0",
                     w16, get_rdy(w16), get_busy(w16), get_res(w16), get_flags(w16));
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; sgn = 1'b0; annul = 1'b0; start32 = 1'b0; start16 = 1'b0;
        op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({rdy32, busy32, dz32, ov32} !== 4'b0 || res32 !== 64'd0 ||
            {rdy16, busy16, dz16, ov16} !== 4'b0 || res16 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: r32=%h %b%b%b%b r16=%h %b%b%b%b, required all 0",
                     res32, rdy32, busy32, dz32, ov32, res16, rdy16, busy16, dz16, ov16);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_unsigned;
        run_op(1'b0, 1'b0, 32'd100, 32'd7, '{res: {32'd2, 32'd14}, dz: 1'b0, ov: 1'b0, lat: 34});
    endtask

    task automatic test_signed;
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, '{res: {32'hFFFF_FFFF, 32'hFFFF_FFFD}, dz: 1'b0, ov: 1'b0, lat: 34});
        run_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, '{res: {32'd1, 32'hFFFF_FFFD}, dz: 1'b0, ov: 1'b0, lat: 34});
    endtask

    task automatic test_div_zero;
        run_op(1'b0, 1'b0, 32'h1234_5678, 32'd0, '{res: {32'h1234_5678, 32'hFFFF_FFFF}, dz: 1'b1, ov: 1'b0, lat: 2});
        run_op(1'b0, 1'b1, 32'hFFFF_FFFB, 32'd0, '{res: {32'hFFFF_FFFB, 32'hFFFF_FFFF}, dz: 1'b1, ov: 1'b0, lat: 2});
    endtask

    task automatic test_overflow;
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, '{res: {32'd0, 32'h8000_0000}, dz: 1'b0, ov: 1'b1, lat: 34});
        run_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, '{res: {32'h8000_0000, 32'd0}, dz: 1'b0, ov: 1'b0, lat: 34});
    endtask

    task automatic test_annul;
        int seen;
        // annul sampled on the 10th edge after start
        @(negedge clk);
        sgn = 1'b0; op1 = 32'd1000; op2 = 32'd3; start32 = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul = 1'b1; start32 = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy32 !== 1'b0 || rdy32 !== 1'b0) begin
            n_fail++;
            $display("FAIL annul_mid: busy=%b ready=%b, required 0 0", busy32, rdy32);
        end
        annul = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rdy32 === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL annul_no_ready: ready high %0d cycles, required 0", seen);
        end
        // annul on the fix-up edge
        @(negedge clk);
        start32 = 1'b1;
        @(posedge clk);
        repeat (32) @(posedge clk);
        @(negedge clk);
        annul = 1'b1; start32 = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy32 !== 1'b0 || rdy32 !== 1'b0 || res32 !== 64'd0) begin
            n_fail++;
            $display("FAIL annul_fixup: busy=%b ready=%b result=%h, required 0 0 0", busy32, rdy32, res32);
        end
        // start together with annul in FREE is ignored
        @(negedge clk);
        start32 = 1'b1; annul = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy32 !== 1'b0) begin
            n_fail++;
            $display("FAIL annul_free: busy=%b, required 0", busy32);
        end
        @(negedge clk);
        start32 = 1'b0; annul = 1'b0;
        run_op(1'b0, 1'b0, 32'd1000, 32'd3, model(1'b0, 1'b0, 32'd1000, 32'd3));
    endtask

    task automatic test_w16;
        int lat;
        run_op(1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_0003, '{res: {32'd0, 16'd0, 16'h5555}, dz: 1'b0, ov: 1'b0, lat: 6});
        run_op(1'b1, 1'b1, 32'h0000_8000, 32'h0000_FFFF, '{res: {32'd0, 16'd0, 16'h8000}, dz: 1'b0, ov: 1'b1, lat: 6});
        // reset mid-operation, with annul also asserted
        @(negedge clk);
        sgn = 1'b0; op1 = 32'h0000_1234; op2 = 32'h0000_0005; start16 = 1'b1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; annul = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({rdy16, busy16, dz16, ov16} !== 4'b0 || res16 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_op: result=%h rdy=%b busy=%b dz=%b ov=%b, required all 0", res16, rdy16, busy16, dz16, ov16);
        end
        @(negedge clk);
        rst = 1'b1; annul = 1'b0; start16 = 1'b0;
        // reset while a result is presented
        @(negedge clk);
        start16 = 1'b1;
        lat = 0;
        @(posedge clk); #1;
        while (rdy16 !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (rdy16 !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_timeout w16: ready=%b after %0d edges, required 1", rdy16, lat);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({rdy16, busy16, dz16, ov16} !== 4'b0 || res16 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_in_end: result=%h rdy=%b busy=%b, required all 0", res16, rdy16, busy16);
        end
        @(negedge clk);
        rst = 1'b1; start16 = 1'b0;
    endtask

    task automatic test_random;
        logic        s;
        logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i % 5 == 4) b = (i < 6) ? 32'hFFFF_FFFF : 32'h0001_0000;
            run_op(i >= 6, s, a, b, model(i >= 6, s, a, b));
        end
    endtask

    task automatic test_back_to_back;
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'd1, model(1'b0, 1'b1, 32'h8000_0000, 32'd1));
        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, model(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
        run_op(1'b1, 1'b1, 32'h0000_FFF9, 32'h0000_0002, '{res: {32'd0, 16'hFFFF, 16'hFFFD}, dz: 1'b0, ov: 1'b0, lat: 6});
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_annul();
        test_w16();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_param.md
# div_param

Parametrised iterative restoring divider for the OpenMIPS EX stage, successor to the fixed 32-bit divider. Performs signed or unsigned WIDTH-bit division, retiring STEPS quotient bits per cycle. It latches operand signs at start, so results do not depend on inputs held stable. It reports divide-by-zero and signed-overflow status alongside a {remainder, quotient} result, using the same start/stop/annul handshake as the existing EX-stage divider.

## Interface
- WIDTH, 32, operand width; even, ≥ 8
- STEPS, 1, quotient bits per cycle; one of 1, 2, 4; must divide WIDTH
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-low (0 = reset)
- signed_div_i  in  1  1 = signed (two's complement) division; sampled at start
- opdata1_i  in  WIDTH  dividend; sampled at start
- opdata2_i  in  WIDTH  divisor; sampled at start
- start_i  in  1  `DivStart (1) requests an operation; `DivStop (0) releases a finished result
- annul_i  in  1  1 = cancel the operation in progress
- result_o  out  2*WIDTH  {remainder, quotient}
- ready_o  out  1  result valid
- busy_o  out  1  1 in every state except FREE
- div_zero_o  out  1  divisor was 0; valid while ready_o = 1
- overflow_o  out  1  signed MIN / −1; valid while ready_o = 1

## Operation
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1 and annul_i=0: latch sign flags neg1 = signed & op1[MSB] and neg2 = signed & op2[MSB], plus the zero and overflow flags.
    - divisor = 0 → BYZERO.
    - Otherwise → ON. Load the magnitude of op1 into the dividend register and the magnitude of op2 into the divisor register; cnt = 0.
  - Otherwise: hold result_o = 0, ready_o = 0, flags = 0.
  - start_i=1 with annul_i=1 in FREE: ignored.
- ON:
  - annul_i=1 → FREE. No result; ready_o stays 0.
  - Else, while cnt < WIDTH/STEPS: perform STEPS restoring steps. Each step trial-subtracts the divisor (WIDTH+1-bit compare) from the partial remainder, shifts left, and appends quotient bit 1 if the difference ≥ 0, else 0. cnt += 1.
  - When cnt = WIDTH/STEPS: fix-up.
    - Quotient = −q if neg1 ^ neg2.
    - Remainder = −r if neg1 (remainder sign follows dividend).
    - → END, cnt = 0.
- BYZERO: quotient = all-ones, remainder = original opdata1 (unmodified); div_zero set; → END.
- END:
  - Drive result_o and flags; ready_o = 1.
  - start_i=0: → FREE, clearing ready_o, result_o and flags on that edge.
  - annul_i ignored.
- Overflow (signed, op1 = 100…0, op2 = all-ones): the normal path yields quotient = 100…0 and remainder = 0; overflow_o = 1.
- Unsigned mode: all magnitudes are the raw operands; neg1 = neg2 = 0.
- Arithmetic: unsigned magnitudes WIDTH bits (MIN magnitude 2^(WIDTH−1) fits); partial remainder WIDTH+1 bits; negation is two's complement modulo 2^WIDTH.

## Timing
- Reset (rst=0 at an edge): state FREE, cnt 0; result_o, ready_o, busy_o, div_zero_o, overflow_o all 0.
- Start sampled at edge E0 → iterations on E1..E(N), N = WIDTH/STEPS → fix-up at E(N+1) → ready_o = 1 after E(N+2).
  - WIDTH=32, STEPS=1: 34 edges.
  - WIDTH=32, STEPS=4: 10 edges.
- Divide by zero: ready_o = 1 after E2.
- busy_o = 1 from E0+ until the edge that returns to FREE.
- Result and flags hold while in END until start_i = 0 is sampled.
- A new start is accepted only in FREE, i.e. no earlier than the edge after the release.
- Operand inputs may change freely after E0.
- annul_i=1 in ON at any cycle, including the fix-up cycle → FREE on that edge.
- Reset mid-operation overrides everything, including annul.

## Structure
- State encodings (`DivFree, `DivByZero, `DivOn, `DivEnd) and `DivStart/`DivStop/`DivResultReady/`DivResultNotReady remain in defines.v; add `DivRstEnable = 1'b0 for this block's reset polarity.
- One sub-module, div_step: combinational single restoring step (partial remainder, divisor, next dividend bit → new remainder, quotient bit). Instantiated STEPS times in a chain via generate.
- Control FSM and registers live in div_param.

## Test plan
- Unsigned, WIDTH=32, STEPS=1: 100 / 7 → result_o = {32'd2, 32'd14}; ready_o rises exactly 34 edges after start; flags 0.
- Signed: −7 / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Also 7 / −2 → quotient −3, remainder +1.
- Divide by zero: 0x12345678 / 0 → quotient 0xFFFFFFFF, remainder 0x12345678, div_zero_o = 1; ready after 2 edges.
- Signed overflow: 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, overflow_o = 1. Same operands unsigned → quotient 0, remainder 0x80000000, overflow_o = 0.
- Annul at cycle 10 of ON → FREE next edge, ready_o never asserts. Then restart with operands changed after E0 → result uses the E0 values.
- WIDTH=16, STEPS=4: 0xFFFF / 0x0003 unsigned → {16'd0, 16'h5555} after 6 edges. rst=0 mid-operation → all outputs 0 the next cycle.
